// File: rtl/fifo_status_monitor_if.sv
// ============================================================================
// Module   : fifo_status_monitor_if
// Brief    : Strobe, threshold and flag bundle between FIFO datapath/FSM and
//            the status monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_status_monitor_if;
    logic       init;
    logic [7:0] UMF;
    logic [7:0] UVC;
    logic [7:0] UD;
    logic [4:0] push;
    logic [4:0] pop;
    logic [4:0] FIFO_EMPTY;
    logic [4:0] FIFO_FULL;
    logic [4:0] FIFO_ALMOST_FULL;
    logic [4:0] FIFO_ERROR;
    logic       pause;

    modport master (
        output init, UMF, UVC, UD, push, pop,
        input  FIFO_EMPTY, FIFO_FULL, FIFO_ALMOST_FULL, FIFO_ERROR, pause
    );

    modport slave (
        input  init, UMF, UVC, UD, push, pop,
        output FIFO_EMPTY, FIFO_FULL, FIFO_ALMOST_FULL, FIFO_ERROR, pause
    );
endinterface

`default_nettype wire

// File: rtl/fifo_status_monitor.sv
// ============================================================================
// Module   : fifo_status_monitor
// Brief    : Occupancy tracking, empty/full/almost-full flags, sticky error
//            flags and pause back-pressure for five FIFOs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_status_monitor #(
    parameter int         DEPTH_MF = 64,
    parameter int         DEPTH_VC = 32,
    parameter int         DEPTH_D  = 32,
    parameter logic [7:0] UMF_RST  = 8'h00,
    parameter logic [7:0] UVC_RST  = 8'h00,
    parameter logic [7:0] UD_RST   = 8'h00
) (
    input  wire logic             clk,
    input  wire logic             reset,
    fifo_status_monitor_if.slave  bus
);

    logic [7:0] thr_mf;
    logic [7:0] thr_vc;
    logic [7:0] thr_d;
    logic [4:0] empty;
    logic [4:0] full;
    logic [4:0] almost_full;
    logic [4:0] error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_mf <= UMF_RST;
            thr_vc <= UVC_RST;
            thr_d  <= UD_RST;
        end else if (bus.init) begin
            thr_mf <= bus.UMF;
            thr_vc <= bus.UVC;
            thr_d  <= bus.UD;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_fifo
        localparam int             DEPTH   = (i == 0) ? DEPTH_MF : ((i < 3) ? DEPTH_VC : DEPTH_D);
        localparam int             W       = $clog2(DEPTH + 1);
        localparam logic [W-1:0]   DEPTH_W = W'(DEPTH);

        logic [W-1:0] count;
        logic         err;
        logic [7:0]   count_ext;
        logic [7:0]   thr;

        assign count_ext = 8'(count);
        assign thr       = (i == 0) ? thr_mf : ((i < 3) ? thr_vc : thr_d);

        // Simultaneous push/pop on an empty FIFO: the pop underflows but the
        // push still lands, so the count becomes one.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                case ({bus.push[i], bus.pop[i]})
                    2'b10: begin
                        if (count == DEPTH_W) err <= 1'b1;
                        else                  count <= count + 1'b1;
                    end
                    2'b01: begin
                        if (count == '0) err <= 1'b1;
                        else             count <= count - 1'b1;
                    end
                    2'b11: begin
                        if (count == '0) begin
                            count <= W'(1);
                            err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign empty[i]       = (count == '0);
        assign full[i]        = (count == DEPTH_W);
        assign almost_full[i] = (thr != 8'h00) && (count_ext >= thr);
        assign error[i]       = err;
    end

    assign bus.FIFO_EMPTY       = empty;
    assign bus.FIFO_FULL        = full;
    assign bus.FIFO_ALMOST_FULL = almost_full;
    assign bus.FIFO_ERROR       = error;
    assign bus.pause            = |almost_full;

endmodule

`default_nettype wire

// File: tb/tb_fifo_status_monitor.sv
// ============================================================================
// Module   : tb_fifo_status_monitor
// Brief    : Directed and randomized checks of fifo_status_monitor against an
//            occupancy-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_status_monitor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_status_monitor_if bus ();

    fifo_status_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_mis = 0;
    int         occ [5];
    int         thr [3];
    int         dep [5] = '{64, 32, 32, 32, 32};
    logic [4:0] m_err;

    function automatic int grp(input int i);
        return (i == 0) ? 0 : ((i < 3) ? 1 : 2);
    endfunction

    function automatic logic [4:0] m_empty();
        logic [4:0] v = '0;
        for (int i = 0; i < 5; i++) v[i] = (occ[i] == 0);
        return v;
    endfunction

    function automatic logic [4:0] m_full();
        logic [4:0] v = '0;
        for (int i = 0; i < 5; i++) v[i] = (occ[i] == dep[i]);
        return v;
    endfunction

    function automatic logic [4:0] m_af();
        logic [4:0] v = '0;
        for (int i = 0; i < 5; i++) v[i] = (thr[grp(i)] != 0) && (occ[i] >= thr[grp(i)]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_empty"}, {3'b0, bus.FIFO_EMPTY},       {3'b0, m_empty()});
        chk({tag, "_full"},  {3'b0, bus.FIFO_FULL},        {3'b0, m_full()});
        chk({tag, "_af"},    {3'b0, bus.FIFO_ALMOST_FULL}, {3'b0, m_af()});
        chk({tag, "_err"},   {3'b0, bus.FIFO_ERROR},       {3'b0, m_err});
        chk({tag, "_pause"}, {7'b0, bus.pause},            {7'b0, |m_af()});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) occ[i] = 0;
        for (int g = 0; g < 3; g++) thr[g] = 0;
        m_err = '0;
    endtask

    // Drive one cycle of strobes, advance the model over the edge, then check.
    task automatic step(input logic [4:0] pu, input logic [4:0] po, input logic in,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input string tag);
        bus.push = pu;
        bus.pop  = po;
        bus.init = in;
        bus.UMF  = a;
        bus.UVC  = b;
        bus.UD   = c;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            if (pu[i] && po[i]) begin
                if (occ[i] == 0) begin
                    occ[i]   = 1;
                    m_err[i] = 1'b1;
                end
            end else if (pu[i]) begin
                if (occ[i] == dep[i]) m_err[i] = 1'b1;
                else                  occ[i]++;
            end else if (po[i]) begin
                if (occ[i] == 0) m_err[i] = 1'b1;
                else             occ[i]--;
            end
        end
        if (in) begin
            thr[0] = int'(a);
            thr[1] = int'(b);
            thr[2] = int'(c);
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(5'b0, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, tag);
    endtask

    // Called just after a rising edge: pulse reset between edges.
    task automatic async_reset(input string tag);
        bus.push = '0;
        bus.pop  = '0;
        bus.init = 1'b0;
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, "_empty_lit"}, {3'b0, bus.FIFO_EMPTY}, 8'h1F);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        bus.init = 1'b0;
        bus.UMF  = 8'h00;
        bus.UVC  = 8'h00;
        bus.UD   = 8'h00;
        bus.push = '0;
        bus.pop  = '0;
        model_reset();
        #1;
        check_all("reset");
        #12 reset = 1'b1;

        step(5'b0, 5'b0, 1'b1, 8'h2A, 8'h17, 8'h1B, "init1");

        for (int k = 1; k <= 42; k++) begin
            step(5'b00001, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, "push0");
            if (k == 1)  chk("empty0_after_first", {7'b0, bus.FIFO_EMPTY[0]}, 8'h00);
            if (k == 41) chk("af0_at_41", {7'b0, bus.FIFO_ALMOST_FULL[0]}, 8'h00);
        end
        chk("af0_at_42",    {7'b0, bus.FIFO_ALMOST_FULL[0]}, 8'h01);
        chk("pause_at_42",  {7'b0, bus.pause}, 8'h01);
        step(5'b0, 5'b00001, 1'b0, 8'h00, 8'h00, 8'h00, "pop0");
        chk("af0_after_pop", {7'b0, bus.FIFO_ALMOST_FULL[0]}, 8'h00);

        for (int k = 0; k < 32; k++) step(5'b00010, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, "fill1");
        chk("full1", {7'b0, bus.FIFO_FULL[1]}, 8'h01);
        step(5'b00010, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, "ovf1");
        chk("err_ovf1", {3'b0, bus.FIFO_ERROR}, 8'h02);
        step(5'b00010, 5'b00010, 1'b0, 8'h00, 8'h00, 8'h00, "pp_full1");
        chk("full1_pp", {7'b0, bus.FIFO_FULL[1]}, 8'h01);

        step(5'b0, 5'b01000, 1'b0, 8'h00, 8'h00, 8'h00, "udf3");
        chk("empty3_udf", {7'b0, bus.FIFO_EMPTY[3]}, 8'h01);
        step(5'b10000, 5'b10000, 1'b0, 8'h00, 8'h00, 8'h00, "pp_empty4");
        chk("err_pp4",   {3'b0, bus.FIFO_ERROR}, 8'h1A);
        chk("empty4_pp", {7'b0, bus.FIFO_EMPTY[4]}, 8'h00);

        step(5'b0, 5'b0, 1'b1, 8'h26, 8'h19, 8'h1C, "init2");
        chk("err_after_init", {3'b0, bus.FIFO_ERROR}, 8'h1A);
        chk("af1_thr25",      {7'b0, bus.FIFO_ALMOST_FULL[1]}, 8'h01);
        step(5'b0, 5'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, "thr_hold");

        for (int k = 0; k < 10; k++) step(5'b00100, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, "midfill2");
        async_reset("rst_mid");
        idle("after_rst");

        step(5'b0, 5'b0, 1'b1, 8'h2A, 8'h17, 8'h1B, "init3");
        for (int k = 0; k < 30; k++) step(5'b00101, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, "fill02");
        for (int k = 0; k < 12; k++) step(5'b00001, 5'b0, 1'b0, 8'h00, 8'h00, 8'h00, "fill0");
        chk("af_before_uvc0", {3'b0, bus.FIFO_ALMOST_FULL}, 8'h05);
        step(5'b0, 5'b0, 1'b1, 8'h2A, 8'h00, 8'h1B, "uvc0");
        chk("af_uvc0",    {3'b0, bus.FIFO_ALMOST_FULL}, 8'h01);
        chk("pause_uvc0", {7'b0, bus.pause}, 8'h01);

        async_reset("rst_rand");
        for (int c = 0; c < 600; c++) begin
            logic [4:0] pu, po;
            logic       in;
            pu = 5'($urandom);
            if ((c / 60) % 2 == 0) po = 5'($urandom & $urandom);
            else                   po = 5'($urandom | $urandom);
            if ((c / 60) % 2 == 1) pu = 5'($urandom & $urandom);
            in = ($urandom_range(0, 15) == 0);
            step(pu, po, in, 8'($urandom_range(0, 70)), 8'($urandom_range(0, 40)),
                 8'($urandom_range(0, 40)), "rand");
            if (c == 300) async_reset("rst_rand_mid");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_status_monitor.md
Name: fifo_status_monitor

Overview:
- Flag-generation end of the flow-control interface. Tracks occupancy of the five FIFOs (index 0 = main FIFO, 1-2 = VC FIFOs, 3-4 = D FIFOs) from their push/pop strobes.
- Produces the FIFO_EMPTY and FIFO_ERROR vectors that the control FSM consumes. Applies the UMF/UVC/UD thresholds that the FSM distributes to generate almost-full and pause back-pressure.

Parameters:
- DEPTH_MF, 64, entries in main FIFO (index 0)
- DEPTH_VC, 32, entries in each VC FIFO (indices 1,2)
- DEPTH_D, 32, entries in each D FIFO (indices 3,4)
- UMF_RST, 8'h00, threshold for index 0 after reset
- UVC_RST, 8'h00, threshold for indices 1,2 after reset
- UD_RST, 8'h00, threshold for indices 3,4 after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- init  in  1  threshold load strobe, level-sampled each rising edge
- UMF  in  8  almost-full threshold, main FIFO
- UVC  in  8  almost-full threshold, VC FIFOs
- UD  in  8  almost-full threshold, D FIFOs
- push  in  5  per-FIFO write strobe, bit i = FIFO i
- pop  in  5  per-FIFO read strobe
- FIFO_EMPTY  out  5  bit i = 1 when occupancy i == 0
- FIFO_FULL  out  5  bit i = 1 when occupancy i == depth i
- FIFO_ALMOST_FULL  out  5  bit i = 1 when threshold i != 0 and occupancy i >= threshold i
- FIFO_ERROR  out  5  sticky overflow/underflow flag per FIFO
- pause  out  1  OR of FIFO_ALMOST_FULL

Behaviour:
Reset (reset=0, async):
- All counters = 0; FIFO_EMPTY = 5'b11111; FIFO_FULL, FIFO_ALMOST_FULL, FIFO_ERROR = 0; pause = 0.
- Threshold registers = UMF_RST / UVC_RST / UD_RST.
- Reset mid-operation discards all counts and errors in the same instant.

Thresholds:
- On a rising edge with init=1 and reset=1: thr_mf <= UMF, thr_vc <= UVC, thr_d <= UD.
- New thresholds take effect on flags from the following cycle.
- While init=0, threshold registers hold; input threshold changes are ignored.
- Threshold 0 disables almost-full for that group.
- Threshold > depth leaves almost-full low while not full.

Counters:
- Width ceil(log2(depth+1)): 7 bits for MF, 6 bits for VC/D.
- Per FIFO i, per edge:
  - push only, count < depth: count+1.
  - push only, count == depth: overflow; count unchanged; ERROR[i] <= 1.
  - pop only, count > 0: count-1.
  - pop only, count == 0: underflow; count unchanged; ERROR[i] <= 1.
  - push and pop, 0 < count <= depth: count unchanged, no error (full included: read frees a slot).
  - push and pop, count == 0: pop is underflow, ERROR[i] <= 1; push accepted; count = 1.
  - neither: hold.
- Each FIFO is independent; any mix of bits may be active in one cycle.

Flags:
- EMPTY, FULL and ALMOST_FULL are combinational from registered counts and thresholds. Latency is 1 cycle: they reflect a strobe on the edge after it is sampled.
- FIFO_ERROR is registered and sticky; it clears only on reset (init does not clear it).
- pause = |FIFO_ALMOST_FULL, same cycle.
- Comparisons are unsigned, with the count zero-extended to 8 bits.
- No wrap-around is possible; counters saturate by the rules above.

Test Plan:
- Reset release, then init=1 for one cycle with UMF=8'h2A, UVC=8'h17, UD=8'h1B -> EMPTY=5'b11111, ERROR=0, pause=0; thresholds latched.
- 42 consecutive pushes on bit 0 -> ALMOST_FULL[0] and pause rise the cycle after the 42nd push; EMPTY[0] falls after the 1st push. One pop -> ALMOST_FULL[0] = 0 next cycle.
- Fill FIFO 1 to 32 (FULL[1]=1), then push again -> ERROR=5'b00010, count stays 32. Push+pop together at full -> count 32, no new error.
- Pop on FIFO 3 while empty -> ERROR[3]=1, EMPTY[3] stays 1. Push+pop on empty FIFO 4 -> ERROR[4]=1, count 1, EMPTY[4]=0.
- With errors set, pulse init with UMF=8'h26, UVC=8'h19, UD=8'h1C -> ERROR unchanged; ALMOST_FULL[1] re-evaluated against 25. Drop reset mid-fill -> all outputs at reset values asynchronously.
- init=1 with UVC=0 while FIFO 2 holds 30 entries -> ALMOST_FULL[2]=0 next cycle; pause follows the remaining bits.
